// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 sampling path: FSM states,
// frame byte positions and the millisecond prescaler length.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    TRIG,
    WAIT_DONE,
    CHECK,
    RETRY_GAP
  } state_t;

  localparam int HUM_INT_HI = 39;
  localparam int HUM_INT_LO = 32;
  localparam int HUM_DEC_HI = 31;
  localparam int HUM_DEC_LO = 24;
  localparam int TMP_INT_HI = 23;
  localparam int TMP_INT_LO = 16;
  localparam int TMP_DEC_HI = 15;
  localparam int TMP_DEC_LO = 8;
  localparam int CSUM_HI    = 7;
  localparam int CSUM_LO    = 0;

  // Clocks below 1 kHz still get a one-cycle millisecond so waits never collapse.
  function automatic int unsigned ms_cycles(input int unsigned clk_hz);
    return (clk_hz < 1000) ? 1 : clk_hz / 1000;
  endfunction

endpackage

// File: rtl/dht11_bin2bcd.sv
// 8-bit binary to 3-digit BCD, shift-add-3, one bit per cycle.
// Built only with DHT11_BCD_EN; o_done pulses 9 cycles after the i_start cycle.
`ifdef DHT11_BCD_EN
module dht11_bin2bcd (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic [11:0] o_bcd,
  output logic        o_done
);

  logic [19:0] r_sh;
  logic [19:0] w_adj;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  always_comb begin
    w_adj = r_sh;
    if (w_adj[11:8]  >= 4'd5) w_adj[11:8]  = w_adj[11:8]  + 4'd3;
    if (w_adj[15:12] >= 4'd5) w_adj[15:12] = w_adj[15:12] + 4'd3;
    if (w_adj[19:16] >= 4'd5) w_adj[19:16] = w_adj[19:16] + 4'd3;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_sh   <= {12'd0, i_bin};
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_sh  <= {w_adj[18:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_bcd  = r_sh[19:8];
  assign o_done = r_done;

endmodule
`endif

// File: rtl/dht11_sample_ctrl.sv
// Periodic DHT11 trigger, checksum validation, retry/fail tracking, last-good-reading hold.
// DHT11_BCD_EN adds BCD copies of the integer bytes; CHECK then waits for the converters.
module dht11_sample_ctrl
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter int unsigned TIMEOUT_MS = 50,
  parameter int unsigned RETRY_MS   = 1000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [39:0] i_frame_in,
  input  logic        i_frame_done,
  output logic        o_start,
  output logic [7:0]  o_humid_int,
  output logic [7:0]  o_humid_dec,
  output logic [7:0]  o_temp_int,
  output logic [7:0]  o_temp_dec,
  output logic        o_data_valid,
  output logic        o_update,
  output logic [7:0]  o_err_cnt,
  output logic        o_fail
`ifdef DHT11_BCD_EN
  ,
  output logic [11:0] o_humid_bcd,
  output logic [11:0] o_temp_bcd
`endif
);

  localparam int unsigned MS = ms_cycles(CLK_HZ);

  state_t      r_state, w_nxt;
  logic [31:0] r_pre, r_ms, w_wait_ms;
  logic [39:0] r_frame;
  logic [3:0]  r_retry, w_retry_inc;
  logic [7:0]  w_sum;
  logic        w_expire, w_good, w_good_evt, w_fail_evt, w_bcd_rdy;
  logic        r_update, r_valid, r_fail;
  logic [7:0]  r_hi, r_hd, r_ti, r_td, r_err;

  assign w_sum = r_frame[HUM_INT_HI:HUM_INT_LO] + r_frame[HUM_DEC_HI:HUM_DEC_LO]
               + r_frame[TMP_INT_HI:TMP_INT_LO] + r_frame[TMP_DEC_HI:TMP_DEC_LO];
  assign w_good      = (w_sum == r_frame[CSUM_HI:CSUM_LO]);
  assign w_retry_inc = r_retry + 4'd1;
  assign w_expire    = (r_pre == MS - 1) && (r_ms == w_wait_ms - 1);

`ifdef DHT11_BCD_EN
  logic        w_conv_start, w_hdone, w_tdone;
  logic [11:0] w_hbcd, w_tbcd, r_hbcd, r_tbcd;

  // Conversion starts on frame_done itself so the result is ready in the last CHECK cycle.
  assign w_conv_start = (r_state == WAIT_DONE) && i_frame_done;

  dht11_bin2bcd u_hum_bcd (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_conv_start),
    .i_bin(i_frame_in[HUM_INT_HI:HUM_INT_LO]), .o_bcd(w_hbcd), .o_done(w_hdone)
  );
  dht11_bin2bcd u_tmp_bcd (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_conv_start),
    .i_bin(i_frame_in[TMP_INT_HI:TMP_INT_LO]), .o_bcd(w_tbcd), .o_done(w_tdone)
  );

  assign w_bcd_rdy = w_hdone & w_tdone;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hbcd <= '0;
      r_tbcd <= '0;
    end else if (w_good_evt) begin
      r_hbcd <= w_hbcd;
      r_tbcd <= w_tbcd;
    end
  end

  assign o_humid_bcd = r_hbcd;
  assign o_temp_bcd  = r_tbcd;
`else
  assign w_bcd_rdy = 1'b1;
`endif

  always_comb begin
    w_wait_ms  = '0;
    w_nxt      = r_state;
    w_good_evt = 1'b0;
    w_fail_evt = 1'b0;
    o_start    = 1'b0;
    case (r_state)
      IDLE:        if (i_enable) w_nxt = WAIT_PERIOD;
      WAIT_PERIOD: begin
        w_wait_ms = PERIOD_MS;
        if (w_expire) w_nxt = TRIG;
      end
      TRIG: begin
        o_start = 1'b1;
        w_nxt   = WAIT_DONE;
      end
      WAIT_DONE: begin
        w_wait_ms = TIMEOUT_MS;
        if (i_frame_done) w_nxt = CHECK;
        else if (w_expire) w_fail_evt = 1'b1;
      end
      CHECK: begin
        if (w_bcd_rdy) begin
          if (w_good) begin
            w_good_evt = 1'b1;
            w_nxt      = WAIT_PERIOD;
          end else begin
            w_fail_evt = 1'b1;
          end
        end
      end
      RETRY_GAP: begin
        w_wait_ms = RETRY_MS;
        if (w_expire) w_nxt = TRIG;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_fail_evt) w_nxt = (w_retry_inc == 4'(MAX_RETRY)) ? WAIT_PERIOD : RETRY_GAP;
    if (!i_enable) begin
      w_nxt      = IDLE;
      w_good_evt = 1'b0;
      w_fail_evt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_pre    <= '0;
      r_ms     <= '0;
      r_frame  <= '0;
      r_retry  <= '0;
      r_update <= 1'b0;
      r_valid  <= 1'b0;
      r_fail   <= 1'b0;
      r_hi     <= '0;
      r_hd     <= '0;
      r_ti     <= '0;
      r_td     <= '0;
      r_err    <= '0;
    end else begin
      r_state <= w_nxt;
      // Every state change restarts the prescaler so each wait is measured from its entry.
      if (w_nxt != r_state) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (r_pre == MS - 1) begin
        r_pre <= '0;
        r_ms  <= r_ms + 32'd1;
      end else begin
        r_pre <= r_pre + 32'd1;
      end
      if (r_state == WAIT_DONE && i_frame_done) r_frame <= i_frame_in;
      r_update <= w_good_evt;
      if (w_good_evt) begin
        r_hi    <= r_frame[HUM_INT_HI:HUM_INT_LO];
        r_hd    <= r_frame[HUM_DEC_HI:HUM_DEC_LO];
        r_ti    <= r_frame[TMP_INT_HI:TMP_INT_LO];
        r_td    <= r_frame[TMP_DEC_HI:TMP_DEC_LO];
        r_valid <= 1'b1;
        r_retry <= '0;
        r_fail  <= 1'b0;
      end
      if (w_fail_evt) begin
        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
        if (w_retry_inc == 4'(MAX_RETRY)) begin
          r_fail  <= 1'b1;
          r_retry <= '0;
        end else begin
          r_retry <= w_retry_inc;
        end
      end
    end
  end

  assign o_humid_int  = r_hi;
  assign o_humid_dec  = r_hd;
  assign o_temp_int   = r_ti;
  assign o_temp_dec   = r_td;
  assign o_data_valid = r_valid;
  assign o_update     = r_update;
  assign o_err_cnt    = r_err;
  assign o_fail       = r_fail;

endmodule

// File: tb/tb_dht11_sample_ctrl.sv
// Directed bench for dht11_sample_ctrl at CLK_HZ=1000 (1 ms = 1 cycle).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_dht11_sample_ctrl;

  localparam int P  = 20;
  localparam int T  = 10;
  localparam int R  = 8;
  localparam int MR = 3;
`ifdef DHT11_BCD_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, frame_done;
  logic [39:0] frame_in;
  logic        start, data_valid, update, fail;
  logic [7:0]  humid_int, humid_dec, temp_int, temp_dec, err_cnt;
`ifdef DHT11_BCD_EN
  logic [11:0] humid_bcd, temp_bcd;
`endif

  int errors = 0;
  int checks = 0;
  int n, starts, updates;

  dht11_sample_ctrl #(
    .CLK_HZ(1000), .PERIOD_MS(P), .TIMEOUT_MS(T), .RETRY_MS(R), .MAX_RETRY(MR)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_frame_in(frame_in), .i_frame_done(frame_done),
    .o_start(start), .o_humid_int(humid_int), .o_humid_dec(humid_dec),
    .o_temp_int(temp_int), .o_temp_dec(temp_dec), .o_data_valid(data_valid),
    .o_update(update), .o_err_cnt(err_cnt), .o_fail(fail)
`ifdef DHT11_BCD_EN
    , .o_humid_bcd(humid_bcd), .o_temp_bcd(temp_bcd)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until start is seen, or -1 if the bound expires.
  task automatic wait_start(input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!start && cnt < limit);
    if (!start) cnt = -1;
  endtask

  // Called in the TRIG cycle; returns in the cycle where a good frame's update is visible.
  task automatic send_frame(input logic [39:0] f);
    tick();
    frame_in   = f;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("upd_early", update, 0);
    repeat (LAT - 1) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_hint"}, humid_int, 0);
    chk({tag, "_tdec"}, temp_dec, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_upd"}, update, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_fail"}, fail, 0);
`ifdef DHT11_BCD_EN
    chk({tag, "_hbcd"}, humid_bcd, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_done = 1'b0; frame_in = '0;
    repeat (3) tick();
    chk_reset_vals("rst");

    rst_n = 1'b1; enable = 1'b1;
    wait_start(200, n);
    chk("first_start", n, P + 1);

    send_frame(40'h3700190050);
    chk("g1_upd", update, 1);
    chk("g1_hint", humid_int, 8'h37);
    chk("g1_hdec", humid_dec, 8'h00);
    chk("g1_tint", temp_int, 8'h19);
    chk("g1_tdec", temp_dec, 8'h00);
    chk("g1_valid", data_valid, 1);
    chk("g1_err", err_cnt, 0);
`ifdef DHT11_BCD_EN
    chk("g1_hbcd", humid_bcd, 12'h055);
    chk("g1_tbcd", temp_bcd, 12'h025);
`endif
    tick();
    chk("g1_upd_one", update, 0);
    wait_start(200, n);
    chk("period", n, P - 1);

    for (int i = 1; i <= MR; i++) begin
      repeat (T) tick();
      chk("to_not_early", err_cnt, i - 1);
      tick();
      chk("to_err", err_cnt, i);
      chk("to_fail", fail, (i == MR) ? 1 : 0);
      chk("to_hint", humid_int, 8'h37);
      wait_start(200, n);
      chk("to_gap", n, (i == MR) ? P : R);
    end

    send_frame(40'h2A05170248);
    chk("g2_fail_clr", fail, 0);
    chk("g2_upd", update, 1);
    chk("g2_hint", humid_int, 8'h2A);
    chk("g2_hdec", humid_dec, 8'h05);
    chk("g2_tint", temp_int, 8'h17);
    chk("g2_tdec", temp_dec, 8'h02);
    chk("g2_err", err_cnt, MR);
    wait_start(200, n);
    chk("g2_period", n, P);

    send_frame(40'h4201200064);
    chk("bad_err", err_cnt, MR + 1);
    chk("bad_upd", update, 0);
    chk("bad_hint", humid_int, 8'h2A);
    chk("bad_tint", temp_int, 8'h17);
    chk("bad_fail", fail, 0);
    wait_start(200, n);
    chk("bad_retry", n, R);

    tick();
    enable = 1'b0;
    tick();
    frame_in = 40'h010203040A;
    frame_done = 1'b1;
    starts = 0; updates = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      frame_done = 1'b0;
      starts += start;
      updates += update;
    end
    chk("dis_starts", starts, 0);
    chk("dis_updates", updates, 0);
    chk("dis_hint", humid_int, 8'h2A);
    chk("dis_err", err_cnt, MR + 1);
    enable = 1'b1;
    wait_start(200, n);
    chk("reen_start", n, P + 1);

    send_frame(40'h0102030407);
    chk("bad2_err", err_cnt, MR + 2);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    wait_start(200, n);
    chk("rst_start", n, P + 1);

    send_frame(40'h3700190050);
    chk("g3_upd", update, 1);
    chk("g3_tint", temp_int, 8'h19);
    chk("g3_err", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
